// File: rtl/vend_ctrl_param.sv
// Coin-accumulating vending controller with configurable price, quarter
// acceptance, cancel/refund and serial change return (dimes before nickels).
module vend_ctrl_param #(
  parameter int unsigned PRICE    = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                nickel_in,
  input  logic                dime_in,
  input  logic                quarter_in,
  input  logic                cancel,
  output logic                dispense,
  output logic                nickel_out,
  output logic                dime_out,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam int unsigned NICKEL_VAL  = 1;
  localparam int unsigned DIME_VAL    = 2;
  localparam int unsigned QUARTER_VAL = 5;

  typedef enum logic [1:0] {
    ACCUM    = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [CREDIT_W-1:0] change;
  logic [CREDIT_W-1:0] change_nxt;
  logic                reject_nxt;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] sum;
  logic                coin_any;
  logic                coin_multi;

  // Pick the winning coin (quarter > dime > nickel) and flag any losers.
  always_comb begin
    coin_any   = nickel_in | dime_in | quarter_in;
    coin_multi = (nickel_in & dime_in) | (nickel_in & quarter_in) | (dime_in & quarter_in);
    coin_val   = '0;
    if (quarter_in) begin
      coin_val = CREDIT_W'(QUARTER_VAL);
    end else if (dime_in) begin
      coin_val = CREDIT_W'(DIME_VAL);
    end else if (nickel_in) begin
      coin_val = CREDIT_W'(NICKEL_VAL);
    end
    sum = credit + coin_val;
  end

  // Next-state, credit/change update and coin rejection.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    change_nxt = change;
    reject_nxt = 1'b0;
    case (state)
      ACCUM: begin
        if (cancel) begin
          // Cancel always beats a coin in the same cycle.
          reject_nxt = coin_any;
          if (credit != '0) begin
            change_nxt = credit;
            credit_nxt = '0;
            state_nxt  = CHANGE;
          end
        end else if (coin_any) begin
          reject_nxt = coin_multi;
          if (sum >= CREDIT_W'(PRICE)) begin
            change_nxt = sum - CREDIT_W'(PRICE);
            credit_nxt = '0;
            state_nxt  = DISPENSE;
          end else begin
            credit_nxt = sum;
          end
        end
      end
      DISPENSE: begin
        reject_nxt = coin_any;
        state_nxt  = (change != '0) ? CHANGE : ACCUM;
      end
      CHANGE: begin
        reject_nxt = coin_any;
        if (change >= CREDIT_W'(DIME_VAL)) begin
          change_nxt = change - CREDIT_W'(DIME_VAL);
        end else begin
          change_nxt = change - CREDIT_W'(NICKEL_VAL);
        end
        if (change_nxt == '0) begin
          state_nxt = ACCUM;
        end
      end
      default: begin
        state_nxt  = ACCUM;
        credit_nxt = '0;
        change_nxt = '0;
      end
    endcase
  end

  // State, credit, change and reject registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ACCUM;
      credit      <= '0;
      change      <= '0;
      coin_reject <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      change      <= change_nxt;
      coin_reject <= reject_nxt;
    end
  end

  // Output decode from registered state and change only.
  always_comb begin
    dispense   = (state == DISPENSE);
    busy       = (state != ACCUM);
    dime_out   = (state == CHANGE) && (change >= CREDIT_W'(DIME_VAL));
    nickel_out = (state == CHANGE) && (change <  CREDIT_W'(DIME_VAL));
  end

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed table-driven bench for vend_ctrl_param (PRICE=5, CREDIT_W=4).
module tb_vend_ctrl_param;

  logic       clock;
  logic       reset;
  logic       nickel_in;
  logic       dime_in;
  logic       quarter_in;
  logic       cancel;
  logic       dispense;
  logic       nickel_out;
  logic       dime_out;
  logic       coin_reject;
  logic       busy;
  logic [3:0] credit;

  int n_tests;
  int n_fail;

  // Expected outputs packed as {dispense, nickel_out, dime_out, coin_reject, busy, credit}
  typedef struct {
    string    name;
    logic     n;
    logic     d;
    logic     q;
    logic     c;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  vend_ctrl_param #(.PRICE(5), .CREDIT_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .quarter_in  (quarter_in),
    .cancel      (cancel),
    .dispense    (dispense),
    .nickel_out  (nickel_out),
    .dime_out    (dime_out),
    .coin_reject (coin_reject),
    .busy        (busy),
    .credit      (credit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add(input string name, input logic n, input logic d, input logic q,
                     input logic c, input logic disp, input logic nout, input logic dout,
                     input logic rej, input logic bsy, input logic [3:0] cred);
    vec_t v;
    v.name = name;
    v.n = n; v.d = d; v.q = q; v.c = c;
    v.exp = {disp, nout, dout, rej, bsy, cred};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {dispense, nickel_out, dime_out, coin_reject, busy, credit};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got disp/nout/dout/rej/busy/credit=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
               name, act[8], act[7], act[6], act[5], act[4], act[3:0],
               exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // One cycle: drive inputs at negedge, sample #1 after the following posedge.
  task automatic apply(input vec_t v);
    @(negedge clock);
    nickel_in  = v.n;
    dime_in    = v.d;
    quarter_in = v.q;
    cancel     = v.c;
    @(posedge clock);
    #1;
    check(v.name, v.exp);
  endtask

  task automatic idle_row(input string name, input logic [8:0] exp);
    vec_t v;
    v.name = name; v.n = 0; v.d = 0; v.q = 0; v.c = 0; v.exp = exp;
    apply(v);
  endtask

  initial begin
    vec_t v;
    n_tests    = 0;
    n_fail     = 0;
    nickel_in  = 0;
    dime_in    = 0;
    quarter_in = 0;
    cancel     = 0;
    reset      = 1'b1;

    //   name          n d q c   disp nout dout rej busy credit
    add("n1",          1,0,0,0,  0,0,0,0,0, 4'd1);
    add("n2",          1,0,0,0,  0,0,0,0,0, 4'd2);
    add("n3",          1,0,0,0,  0,0,0,0,0, 4'd3);
    add("n4",          1,0,0,0,  0,0,0,0,0, 4'd4);
    add("n5_vend",     1,0,0,0,  1,0,0,0,1, 4'd0);
    add("n5_done",     0,0,0,0,  0,0,0,0,0, 4'd0);
    add("d1",          0,1,0,0,  0,0,0,0,0, 4'd2);
    add("d2",          0,1,0,0,  0,0,0,0,0, 4'd4);
    add("d3_vend",     0,1,0,0,  1,0,0,0,1, 4'd0);
    add("d3_nickel",   0,0,0,0,  0,1,0,0,1, 4'd0);
    add("d3_done",     0,0,0,0,  0,0,0,0,0, 4'd0);
    add("ddq_d1",      0,1,0,0,  0,0,0,0,0, 4'd2);
    add("ddq_d2",      0,1,0,0,  0,0,0,0,0, 4'd4);
    add("ddq_vend",    0,0,1,0,  1,0,0,0,1, 4'd0);
    add("ddq_dime1",   0,0,0,0,  0,0,1,0,1, 4'd0);
    add("ddq_dime2",   0,0,0,0,  0,0,1,0,1, 4'd0);
    add("ddq_done",    0,0,0,0,  0,0,0,0,0, 4'd0);
    add("dnc_d",       0,1,0,0,  0,0,0,0,0, 4'd2);
    add("dnc_n",       1,0,0,0,  0,0,0,0,0, 4'd3);
    add("dnc_cancel",  0,0,0,1,  0,0,1,0,1, 4'd0);
    add("dnc_nickel",  0,0,0,0,  0,1,0,0,1, 4'd0);
    add("dnc_done",    0,0,0,0,  0,0,0,0,0, 4'd0);
    add("qd_vend",     0,1,1,0,  1,0,0,1,1, 4'd0);
    add("qd_rej_n",    1,0,0,0,  0,0,0,1,0, 4'd0);
    add("qd_done",     0,0,0,0,  0,0,0,0,0, 4'd0);
    add("cancel_zero", 0,0,0,1,  0,0,0,0,0, 4'd0);
    add("nd_pri",      1,1,0,0,  0,0,0,1,0, 4'd2);
    add("cn_refund",   1,0,0,1,  0,0,1,1,1, 4'd0);
    add("cn_done",     0,0,0,0,  0,0,0,0,0, 4'd0);
    add("q_credit",    0,0,1,0,  1,0,0,0,1, 4'd0);
    add("q_done",      0,0,0,0,  0,0,0,0,0, 4'd0);
    add("bb_n1",       1,0,0,0,  0,0,0,0,0, 4'd1);
    add("bb_d",        0,1,0,0,  0,0,0,0,0, 4'd3);
    add("bb_q_vend",   0,0,1,0,  1,0,0,0,1, 4'd0);
    add("bb_dime",     0,0,0,0,  0,0,1,0,1, 4'd0);
    add("bb_nickel",   0,0,0,0,  0,1,0,0,1, 4'd0);
    add("bb_done",     0,0,0,0,  0,0,0,0,0, 4'd0);

    #1;
    check("reset_state", 9'b0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) apply(vecs[i]);

    // Reset during the first change cycle of the dime-dime-quarter vend.
    v.n = 0; v.d = 1; v.q = 0; v.c = 0; v.name = "rst_d1"; v.exp = {5'b00000, 4'd2}; apply(v);
    v.name = "rst_d2"; v.exp = {5'b00000, 4'd4}; apply(v);
    v.d = 0; v.q = 1; v.name = "rst_vend"; v.exp = {5'b10001, 4'd0}; apply(v);
    idle_row("rst_dime1", {5'b00101, 4'd0});
    #2;
    reset = 1'b1;
    #1;
    check("rst_async", 9'b0);
    @(negedge clock);
    reset = 1'b0;
    idle_row("rst_after1", 9'b0);
    idle_row("rst_after2", 9'b0);
    v.n = 1; v.d = 0; v.q = 0; v.c = 0; v.name = "rst_nickel"; v.exp = {5'b00000, 4'd1}; apply(v);
    idle_row("rst_hold", {5'b00000, 4'd1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
